// File: rtl/mmio_port.sv
// mmio_port: memory-mapped I/O responder for a 4-byte window on the RAM bus.
//
// Register map (offset = addr[1:0], window = BASE..BASE+3):
//   0 TXDATA  write pushes din into the TX FIFO; reads return 8'h00
//   1 STATUS  {3'b0, rx_overrun, tx_overflow, rx_valid, tx_empty, tx_full};
//             a write clears bit3/bit4 wherever din holds a 1
//   2 RXDATA  receive holding register; any write acknowledges it
//   3 TIMER   free-running counter; a write loads din and clears the prescaler
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   din, addr, we       processor write data, address, write enable
//   dout                registered read data (one-cycle latency, like RAM)
//   io_sel              combinational window decode
//   tx_data, tx_valid   head of TX FIFO and its not-empty flag
//   tx_ready            consumer pops the head on tx_valid && tx_ready
//   rx_data, rx_strobe  incoming byte and its single-cycle capture strobe
module mmio_port #(
    parameter logic [7:0] BASE     = 8'hFC,
    parameter int         DEPTH    = 4,
    parameter int         PRESCALE = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] din,
    input  logic [7:0] addr,
    input  logic       we,
    output logic [7:0] dout,
    output logic       io_sel,
    output logic [7:0] tx_data,
    output logic       tx_valid,
    input  logic       tx_ready,
    input  logic [7:0] rx_data,
    input  logic       rx_strobe
);

    localparam int               PTR_W   = $clog2(DEPTH);
    localparam int               CNT_W   = $clog2(DEPTH) + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
    localparam logic [7:0]       PRE_MAX = 8'(PRESCALE - 1);

    logic [7:0]       mem_q [DEPTH];
    logic [PTR_W-1:0] wptr_q, wptr_d;
    logic [PTR_W-1:0] rptr_q, rptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             tx_ovf_q, tx_ovf_d;
    logic [7:0]       rx_hold_q, rx_hold_d;
    logic             rx_valid_q, rx_valid_d;
    logic             rx_ovr_q, rx_ovr_d;
    logic [7:0]       timer_q, timer_d;
    logic [7:0]       pre_q, pre_d;
    logic [7:0]       dout_q, dout_d;

    logic [1:0] off;
    logic       wr, push, pop, push_ok, tx_full, tick;
    logic [7:0] status;

    assign io_sel   = (addr[7:2] == BASE[7:2]);
    assign off      = addr[1:0];
    assign wr       = we && io_sel;
    assign tx_full  = (count_q == DEPTH_C);
    assign tx_valid = (count_q != '0);
    // Gate the head so the output is a clean 0 while the FIFO is empty.
    assign tx_data  = tx_valid ? mem_q[rptr_q] : 8'h00;
    assign dout     = dout_q;

    assign push = wr && (off == 2'd0);
    assign pop  = tx_valid && tx_ready;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    assign push_ok = push && (!tx_full || pop);
    assign tick    = (pre_q == PRE_MAX);
    assign status  = {3'b000, rx_ovr_q, tx_ovf_q, rx_valid_q, !tx_valid, tx_full};

    always_comb begin
        wptr_d     = wptr_q;
        rptr_d     = rptr_q;
        count_d    = count_q;
        tx_ovf_d   = tx_ovf_q;
        rx_hold_d  = rx_hold_q;
        rx_valid_d = rx_valid_q;
        rx_ovr_d   = rx_ovr_q;
        timer_d    = timer_q;
        pre_d      = pre_q;
        dout_d     = 8'h00;

        if (push_ok) wptr_d = wptr_q + 1'b1;
        if (pop)     rptr_d = rptr_q + 1'b1;
        count_d = count_q + CNT_W'(push_ok) - CNT_W'(pop);

        // Clear-by-write first, so a coincident new event still sets the flag.
        if (wr && off == 2'd1 && din[3]) tx_ovf_d = 1'b0;
        if (wr && off == 2'd1 && din[4]) rx_ovr_d = 1'b0;
        if (push && !push_ok)            tx_ovf_d = 1'b1;

        if (wr && off == 2'd2) rx_valid_d = 1'b0;
        if (rx_strobe) begin
            rx_hold_d  = rx_data;
            rx_valid_d = 1'b1;
            if (rx_valid_q && !(wr && off == 2'd2)) rx_ovr_d = 1'b1;
        end

        // A timer write overrides a tick landing on the same edge.
        if (wr && off == 2'd3) begin
            timer_d = din;
            pre_d   = 8'h00;
        end else if (tick) begin
            timer_d = timer_q + 8'h01;
            pre_d   = 8'h00;
        end else begin
            pre_d = pre_q + 8'h01;
        end

        if (io_sel) begin
            case (off)
                2'd0:    dout_d = 8'h00;
                2'd1:    dout_d = status;
                2'd2:    dout_d = rx_hold_q;
                default: dout_d = timer_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wptr_q] <= din;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q     <= '0;
            rptr_q     <= '0;
            count_q    <= '0;
            tx_ovf_q   <= 1'b0;
            rx_hold_q  <= 8'h00;
            rx_valid_q <= 1'b0;
            rx_ovr_q   <= 1'b0;
            timer_q    <= 8'h00;
            pre_q      <= 8'h00;
            dout_q     <= 8'h00;
        end else begin
            wptr_q     <= wptr_d;
            rptr_q     <= rptr_d;
            count_q    <= count_d;
            tx_ovf_q   <= tx_ovf_d;
            rx_hold_q  <= rx_hold_d;
            rx_valid_q <= rx_valid_d;
            rx_ovr_q   <= rx_ovr_d;
            timer_q    <= timer_d;
            pre_q      <= pre_d;
            dout_q     <= dout_d;
        end
    end

endmodule

// File: tb/tb_mmio_port.sv
// Bench for mmio_port: a queue/arithmetic model checked every cycle, plus
// directed vectors with literal expectations from the register map.
module tb_mmio_port;

    localparam logic [7:0] BASE     = 8'hFC;
    localparam int         DEPTH    = 4;
    localparam int         PRESCALE = 3;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] din = 8'h00;
    logic [7:0] addr = 8'h00;
    logic       we = 1'b0;
    logic [7:0] dout;
    logic       io_sel;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready = 1'b0;
    logic [7:0] rx_data = 8'h00;
    logic       rx_strobe = 1'b0;

    int checks = 0;
    int errors = 0;

    mmio_port #(.BASE(BASE), .DEPTH(DEPTH), .PRESCALE(PRESCALE)) dut (
        .clk(clk), .rst_n(rst_n), .din(din), .addr(addr), .we(we),
        .dout(dout), .io_sel(io_sel), .tx_data(tx_data), .tx_valid(tx_valid),
        .tx_ready(tx_ready), .rx_data(rx_data), .rx_strobe(rx_strobe)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [7:0] m_q [$];
    bit         m_ovf = 0, m_rxv = 0, m_ovr = 0;
    logic [7:0] m_rxd = 8'h00;
    logic [7:0] m_tload = 8'h00;
    int         m_tcyc = 0;
    logic [7:0] m_dout = 8'h00;

    function automatic bit in_win(input logic [7:0] a);
        return (int'(a) >= int'(BASE)) && (int'(a) <= int'(BASE) + 3);
    endfunction

    function automatic logic [7:0] m_timer();
        return 8'((int'(m_tload) + m_tcyc / PRESCALE) % 256);
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_q.delete();
            m_ovf = 0; m_rxv = 0; m_ovr = 0; m_rxd = 8'h00;
            m_tload = 8'h00; m_tcyc = 0; m_dout = 8'h00;
        end else begin
            bit sel, was_full, popped, wr, ack, ovf_set, ovr_set;
            int o;
            sel = in_win(addr);
            o = int'(addr) - int'(BASE);
            wr = we && sel;
            if (!sel)        m_dout = 8'h00;
            else if (o == 0) m_dout = 8'h00;
            else if (o == 1) m_dout = {3'b000, m_ovr, m_ovf, m_rxv, m_q.size() == 0, m_q.size() == DEPTH};
            else if (o == 2) m_dout = m_rxd;
            else             m_dout = m_timer();
            was_full = (m_q.size() == DEPTH);
            popped = (m_q.size() > 0) && tx_ready;
            if (popped) void'(m_q.pop_front());
            ovf_set = 0;
            if (wr && o == 0) begin
                if (!was_full || popped) m_q.push_back(din);
                else ovf_set = 1;
            end
            ack = wr && o == 2;
            ovr_set = rx_strobe && m_rxv && !ack;
            m_ovf = (m_ovf && !(wr && o == 1 && din[3])) || ovf_set;
            m_ovr = (m_ovr && !(wr && o == 1 && din[4])) || ovr_set;
            if (rx_strobe) begin m_rxv = 1; m_rxd = rx_data; end
            else if (ack) m_rxv = 0;
            if (wr && o == 3) begin m_tload = din; m_tcyc = 0; end
            else m_tcyc++;
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        if (rst_n) begin
            chk("model_dout", dout, m_dout);
            chk("model_io_sel", {7'b0, io_sel}, {7'b0, in_win(addr)});
            chk("model_tx_valid", {7'b0, tx_valid}, {7'b0, m_q.size() > 0});
            chk("model_tx_data", tx_data, (m_q.size() > 0) ? m_q[0] : 8'h00);
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic tick();
        @(posedge clk); #2;
    endtask

    task automatic wr_reg(input logic [7:0] a, input logic [7:0] d);
        addr = a; din = d; we = 1'b1;
        tick();
        we = 1'b0; addr = 8'h00;
    endtask

    task automatic rd_chk(input string name, input logic [7:0] a, input logic [7:0] exp);
        addr = a; we = 1'b0;
        @(posedge clk); #1;
        chk(name, dout, exp);
        #1;
        addr = 8'h00;
    endtask

    initial begin
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b1;
        #1;
        chk("reset_dout", dout, 8'h00);
        chk("reset_tx_valid", {7'b0, tx_valid}, 8'h00);
        chk("reset_tx_data", tx_data, 8'h00);
        chk("reset_io_sel", {7'b0, io_sel}, 8'h00);
        #1;
        rd_chk("reset_status", 8'hFD, 8'h02);

        // FIFO ordering
        wr_reg(8'hFC, 8'h11);
        wr_reg(8'hFC, 8'h22);
        wr_reg(8'hFC, 8'h33);
        chk("fifo_head0", tx_data, 8'h11);
        tx_ready = 1'b1;
        tick(); chk("fifo_head1", tx_data, 8'h22);
        tick(); chk("fifo_head2", tx_data, 8'h33);
        tick(); chk("fifo_drained", {7'b0, tx_valid}, 8'h00);
        tx_ready = 1'b0;

        // Overflow and simultaneous push/pop while full
        for (int i = 1; i <= 5; i++) wr_reg(8'hFC, 8'(i));
        rd_chk("ovf_status", 8'hFD, 8'h09);
        wr_reg(8'hFD, 8'h08);
        rd_chk("ovf_cleared", 8'hFD, 8'h01);
        chk("ovf_head", tx_data, 8'h01);
        tx_ready = 1'b1;
        wr_reg(8'hFC, 8'h06);
        tx_ready = 1'b0;
        rd_chk("full_pushpop", 8'hFD, 8'h01);
        chk("full_pushpop_head", tx_data, 8'h02);
        tx_ready = 1'b1;
        repeat (3) tick();
        chk("tail_after_pushpop", tx_data, 8'h06);
        tick();
        tx_ready = 1'b0;

        // RX holding register
        rx_data = 8'hA5; rx_strobe = 1'b1; tick(); rx_strobe = 1'b0;
        rd_chk("rx_status", 8'hFD, 8'h06);
        rd_chk("rx_data1", 8'hFE, 8'hA5);
        rx_data = 8'h5A; rx_strobe = 1'b1; tick(); rx_strobe = 1'b0;
        rd_chk("rx_data2", 8'hFE, 8'h5A);
        rd_chk("rx_overrun", 8'hFD, 8'h16);
        wr_reg(8'hFD, 8'h10);
        rd_chk("rx_ovr_clear", 8'hFD, 8'h06);
        rx_data = 8'h77; rx_strobe = 1'b1;
        wr_reg(8'hFE, 8'h00);
        rx_strobe = 1'b0;
        rd_chk("rx_strobe_ack", 8'hFD, 8'h06);
        rd_chk("rx_data3", 8'hFE, 8'h77);
        wr_reg(8'hFE, 8'h00);
        rd_chk("rx_ack", 8'hFD, 8'h02);

        // Timer
        wr_reg(8'hFF, 8'h00);
        repeat (9) tick();
        rd_chk("timer_9", 8'hFF, 8'h03);
        wr_reg(8'hFF, 8'hFE);
        repeat (6) tick();
        rd_chk("timer_wrap", 8'hFF, 8'h00);
        wr_reg(8'hFF, 8'h00);
        repeat (2) tick();
        wr_reg(8'hFF, 8'h40);
        rd_chk("timer_wr_tick", 8'hFF, 8'h40);

        // Decode
        addr = 8'hFB; #1;
        chk("decode_sel_fb", {7'b0, io_sel}, 8'h00);
        #1;
        rd_chk("decode_fb", 8'hFB, 8'h00);
        rd_chk("decode_00", 8'h00, 8'h00);
        wr_reg(8'hFB, 8'h55);
        wr_reg(8'hF8, 8'h1F);
        rd_chk("decode_status", 8'hFD, 8'h02);
        chk("decode_tx_valid", {7'b0, tx_valid}, 8'h00);

        // Reset mid-transfer discards FIFO contents
        wr_reg(8'hFC, 8'hAA);
        wr_reg(8'hFC, 8'hBB);
        #1 rst_n = 1'b0;
        #1;
        chk("async_rst_tx_valid", {7'b0, tx_valid}, 8'h00);
        chk("async_rst_tx_data", tx_data, 8'h00);
        tick();
        rst_n = 1'b1;
        rd_chk("post_rst_status", 8'hFD, 8'h02);
        repeat (2) tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
